// File: rtl/hs_fifo_replay.sv
// rtl/hs_fifo_replay.sv - valid/ready FIFO with registered show-ahead output, occupancy flags
// Optional mark/rewind replay is built when HS_FIFO_REPLAY_EN is defined.
module hs_fifo_replay #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                       clk_core,
    input  logic                       rst_core,
    input  logic                       flush,
    input  logic                       mark,
    input  logic                       rewind,
    output logic                       ready_o,
    input  logic                       valid_i,
    input  logic [WIDTH-1:0]           in,
    input  logic                       ready_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr, head_ptr;
    logic [CW-1:0]    live;
    logic             valid_q;
    logic [WIDTH-1:0] out_q;

    logic [PW-1:0]    wr_d, head_d, head_nx, fetch_ptr;
    logic [CW-1:0]    live_d, live_nx, unread;
    logic             valid_d;
    logic [WIDTH-1:0] out_d, load_data;
    logic             push, pop, push_acc, load;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef HS_FIFO_REPLAY_EN
    logic [PW-1:0] mark_ptr, mark_d;
    logic [CW-1:0] count_q, count_d;
    assign count = count_q;
`else
    logic unused_replay;
    assign unused_replay = mark ^ rewind;
    assign count = live;
`endif

    assign ready_o      = (count < CW'(DEPTH));
    assign valid_o      = valid_q;
    assign out          = out_q;
    assign almost_full  = (int'(count) >= AFULL_THRESH);
    assign almost_empty = (int'(count) <= AEMPTY_THRESH);

    // head_ptr is the read position (word on the output when valid_o);
    // live counts entries from head_ptr up to wr_ptr.
    always_comb begin
        push      = valid_i & ready_o;
        pop       = valid_q & ready_i;
        push_acc  = push & ~flush;
        head_nx   = pop ? ptr_inc(head_ptr) : head_ptr;
        fetch_ptr = valid_q ? ptr_inc(head_ptr) : head_ptr;
        unread    = live - CW'(valid_q);
        live_nx   = live + CW'(push_acc) - CW'(pop);
        load      = (~valid_q | pop) & ((unread != '0) | push_acc);
        // With nothing unread in storage, a same-cycle push bypasses straight to the output.
        load_data = (unread != '0) ? mem[fetch_ptr] : in;

        wr_d    = push_acc ? ptr_inc(wr_ptr) : wr_ptr;
        head_d  = head_nx;
        live_d  = live_nx;
        valid_d = valid_q;
        out_d   = out_q;
        if (load) begin
            valid_d = 1'b1;
            out_d   = load_data;
        end else if (pop) begin
            valid_d = 1'b0;
        end

`ifdef HS_FIFO_REPLAY_EN
        mark_d  = mark_ptr;
        count_d = count_q + CW'(push_acc);
        if (rewind) begin
            head_d  = mark_ptr;
            live_d  = count_q + CW'(push_acc);
            valid_d = 1'b0;
            out_d   = out_q;
        end else if (mark) begin
            // Everything before the new mark is released back to the writer.
            mark_d  = head_nx;
            count_d = live_nx;
        end
        if (flush) begin
            mark_d  = '0;
            count_d = '0;
        end
`endif

        if (flush) begin
            wr_d    = '0;
            head_d  = '0;
            live_d  = '0;
            valid_d = 1'b0;
            out_d   = out_q;
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            wr_ptr   <= '0;
            head_ptr <= '0;
            live     <= '0;
            valid_q  <= 1'b0;
            out_q    <= '0;
        end else begin
            wr_ptr   <= wr_d;
            head_ptr <= head_d;
            live     <= live_d;
            valid_q  <= valid_d;
            out_q    <= out_d;
        end
    end

`ifdef HS_FIFO_REPLAY_EN
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            mark_ptr <= '0;
            count_q  <= '0;
        end else begin
            mark_ptr <= mark_d;
            count_q  <= count_d;
        end
    end
`endif

    always_ff @(posedge clk_core) begin
        if (push_acc) begin
            mem[wr_ptr] <= in;
        end
    end

endmodule

// File: tb/tb_hs_fifo_replay.sv
// tb/tb_hs_fifo_replay.sv - scoreboard bench for hs_fifo_replay at DEPTH=4, WIDTH=8
module tb_hs_fifo_replay;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk_core = 1'b0;
    logic             rst_core = 1'b1;
    logic             flush    = 1'b0;
    logic             mark     = 1'b0;
    logic             rewind   = 1'b0;
    logic             valid_i  = 1'b0;
    logic [WIDTH-1:0] din      = '0;
    logic             ready_i  = 1'b0;
    logic             ready_o, valid_o, almost_full, almost_empty;
    logic [WIDTH-1:0] dout;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] obs_q[$];

    hs_fifo_replay #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_core(clk_core), .rst_core(rst_core), .flush(flush), .mark(mark), .rewind(rewind),
        .ready_o(ready_o), .valid_i(valid_i), .in(din), .ready_i(ready_i), .valid_o(valid_o),
        .out(dout), .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
    );

    always #5 clk_core = ~clk_core;

    // Records accepted pushes as expectations and observed pops as results, then advances one cycle.
    task automatic tick();
        if (valid_i && ready_o && !flush && !rst_core) exp_q.push_back(din);
        if (valid_o && ready_i && !rst_core) obs_q.push_back(dout);
        @(posedge clk_core);
        #1;
    endtask

    task automatic test_reset();
        rst_core = 1'b1; valid_i = 1'b1; din = 8'h5A;
        tick(); tick();
        rst_core = 1'b0; valid_i = 1'b0;
        exp_q.delete(); obs_q.delete();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_o); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_out got %0h want 0", dout); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %0b want 0", almost_full); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %0b want 1", almost_empty); end
    endtask

    task automatic test_single();
        valid_i = 1'b1; din = 8'h11; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", valid_o); end
        checks++; if (dout !== 8'h11) begin errors++; $display("FAIL single_out got %0h want 11", dout); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", count); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", count); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_empty got %0b want 0", valid_o); end
        checks++; if (dout !== 8'h11) begin errors++; $display("FAIL single_hold got %0h want 11", dout); end
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL single_sb got %0d words want %0d", obs_q.size(), exp_q.size());
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_full();
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; din = 8'(8'hA0 + i);
            tick();
        end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", ready_o); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL full_afull got %0b want 1", almost_full); end
        checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL full_aempty got %0b want 0", almost_empty); end
        din = 8'hEE;
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_blocked got %0d want 4", count); end
        valid_i = 1'b0; ready_i = 1'b1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL full_comb_ready got %0b want 0", ready_o); end
        tick();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %0b want 1", ready_o); end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d want 3", count); end
        for (int i = 0; i < 10 && (valid_o || count != 0); i++) tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drain got %0d want 0", count); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL full_drain_aempty got %0b want 1", almost_empty); end
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL full_sb_len got %0d want 4", obs_q.size()); end
        for (int i = 0; i < 4 && i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_sb[%0d] got %0h want %0h", i, obs_q[i], exp_q[i]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            valid_i = 1'b1; din = 8'(8'hB0 + i);
            tick();
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_bubble[%0d] got %0b want 1", i, valid_o); end
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count[%0d] got %0d want 1", i, count); end
        end
        valid_i = 1'b0;
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_end_count got %0d want 0", count); end
        checks++; if (obs_q.size() != 20) begin errors++; $display("FAIL b2b_sb_len got %0d want 20", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_sb[%0d] got %0h want %0h", i, obs_q[i], exp_q[i]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_stall_flush();
        ready_i = 1'b0; valid_i = 1'b1; din = 8'h22;
        tick();
        din = 8'h33;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (valid_o !== 1'b1 || dout !== 8'h22) begin errors++; $display("FAIL stall_hold[%0d] got %0b/%0h want 1/22", i, valid_o, dout); end
            tick();
        end
        flush = 1'b1; valid_i = 1'b1; din = 8'h44;
        tick();
        flush = 1'b0; valid_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", valid_o); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b want 1", ready_o); end
        tick();
        checks++; if (valid_o !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL flush_discard got %0b/%0d want 0/0", valid_o, count); end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef HS_FIFO_REPLAY_EN
    task automatic test_replay();
        ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            valid_i = 1'b1; din = 8'(i);
            tick();
        end
        valid_i = 1'b0; mark = 1'b1;
        tick();
        mark = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL rp_mark_count got %0d want 4", count); end
        ready_i = 1'b1;
        checks++; if (valid_o !== 1'b1 || dout !== 8'h01) begin errors++; $display("FAIL rp_first got %0b/%0h want 1/01", valid_o, dout); end
        tick();
        checks++; if (dout !== 8'h02) begin errors++; $display("FAIL rp_second got %0h want 02", dout); end
        tick();
        ready_i = 1'b0; rewind = 1'b1;
        tick();
        rewind = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rp_rewind_gap got %0b want 0", valid_o); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL rp_rewind_count got %0d want 4", count); end
        tick();
        checks++; if (valid_o !== 1'b1 || dout !== 8'h01) begin errors++; $display("FAIL rp_replay1 got %0b/%0h want 1/01", valid_o, dout); end
        ready_i = 1'b1;
        tick();
        checks++; if (dout !== 8'h02) begin errors++; $display("FAIL rp_replay2 got %0h want 02", dout); end
        tick();
        ready_i = 1'b0;
        checks++; if (dout !== 8'h03 || count !== 3'd4) begin errors++; $display("FAIL rp_pending got %0h/%0d want 03/4", dout, count); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_replay_mark_rewind();
        mark = 1'b1; rewind = 1'b1;
        tick();
        mark = 1'b0; rewind = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mr_gap got %0b want 0", valid_o); end
        tick();
        checks++; if (valid_o !== 1'b1 || dout !== 8'h01) begin errors++; $display("FAIL mr_from_mark got %0b/%0h want 1/01", valid_o, dout); end
        ready_i = 1'b1;
        tick();
        rst_core = 1'b1;
        tick();
        rst_core = 1'b0; ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || dout !== 8'h00 || count !== 3'd0 || ready_o !== 1'b1 || almost_full !== 1'b0 || almost_empty !== 1'b1) begin
            errors++; $display("FAIL mr_reset got v%0b o%0h c%0d r%0b want v0 o0 c0 r1", valid_o, dout, count, ready_o);
        end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_stall_flush();
`ifdef HS_FIFO_REPLAY_EN
        test_reset();
        test_replay();
        test_replay_mark_rewind();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
